uar_pkt_ctrl: RTL and testbench

UAR_PKT_CTRL -- requirements
Module: uar_pkt_ctrl

---
 rtl/uar_pkt_ctrl.sv | 127 ++++++++++++
 tb/tb_uar_pkt_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/uar_pkt_ctrl.sv
// Packet receive controller: watches the receiver ready line, captures and
// classifies finished packets into a one-deep buffer, and resets a stuck receiver.
module uar_pkt_ctrl #(
  parameter int          PKT_LNGTH      = 162,
  parameter int          TIMEOUT_CYCLES = 1_500_000,
  parameter int          RST_PULSE      = 4,
  parameter logic [7:0]  HDR_VAL        = 8'hA5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rx_ready_in,
  input  logic [PKT_LNGTH-1:0] rx_data_in,
  output logic                 rx_rst_out,
  output logic [PKT_LNGTH-1:0] pkt_out,
  output logic                 pkt_valid_out,
  input  logic                 pkt_ready_in,
  output logic                 busy_out,
  output logic [7:0]           pkt_count_out,
  output logic [7:0]           bad_count_out,
  output logic [7:0]           drop_count_out,
  output logic [7:0]           timeout_count_out
);

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    RXRST = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   timer;
  logic [PW-1:0] pulse_cnt;
  logic          rdy_q;

  logic fall, rise, capture, hdr_ok, handshake, load, drop, bad, timeout;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign fall      = rdy_q & ~rx_ready_in;
  assign rise      = ~rdy_q & rx_ready_in;
  assign capture   = (state == RECV) & rise;
  assign hdr_ok    = (rx_data_in[7:0] == HDR_VAL);
  assign handshake = pkt_valid_out & pkt_ready_in;
  // A good packet may replace the buffer only if it is empty or draining now.
  assign load      = capture & hdr_ok & (~pkt_valid_out | handshake);
  assign drop      = capture & hdr_ok & pkt_valid_out & ~pkt_ready_in;
  assign bad       = capture & ~hdr_ok;
  // A rise on the timeout cycle wins: the packet is captured, not aborted.
  assign timeout   = (state == RECV) & ~rise & (timer == 32'(TIMEOUT_CYCLES - 1));

  // NOTE: every register here uses non-blocking assignment so all state
  // updates on an edge see the same pre-edge values, matching the hardware.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= IDLE;
      timer             <= '0;
      pulse_cnt         <= '0;
      rx_rst_out        <= 1'b0;
      busy_out          <= 1'b0;
      timeout_count_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            state    <= RECV;
            timer    <= '0;
            busy_out <= 1'b1;
          end
        end
        RECV: begin
          timer <= timer + 32'd1;
          if (rise) begin
            state    <= IDLE;
            busy_out <= 1'b0;
          end else if (timeout) begin
            state             <= RXRST;
            rx_rst_out        <= 1'b1;
            pulse_cnt         <= '0;
            timeout_count_out <= sat_inc(timeout_count_out);
          end
        end
        RXRST: begin
          if (pulse_cnt == PW'(RST_PULSE - 1)) begin
            state      <= IDLE;
            rx_rst_out <= 1'b0;
            busy_out   <= 1'b0;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          rx_rst_out <= 1'b0;
          busy_out   <= 1'b0;
        end
      endcase
    end
  end

  // Buffer and classification counters run regardless of the monitor state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rdy_q          <= 1'b1;
      pkt_out        <= '0;
      pkt_valid_out  <= 1'b0;
      pkt_count_out  <= '0;
      bad_count_out  <= '0;
      drop_count_out <= '0;
    end else begin
      rdy_q <= rx_ready_in;
      if (load) begin
        pkt_out       <= rx_data_in;
        pkt_valid_out <= 1'b1;
        pkt_count_out <= sat_inc(pkt_count_out);
      end else if (handshake) begin
        pkt_valid_out <= 1'b0;
      end
      if (bad)  bad_count_out  <= sat_inc(bad_count_out);
      if (drop) drop_count_out <= sat_inc(drop_count_out);
    end
  end

endmodule

// File: tb/tb_uar_pkt_ctrl.sv
// Directed bench for uar_pkt_ctrl with a short timeout so the receiver reset
// path can be exercised quickly.
module tb_uar_pkt_ctrl;

  localparam int PL = 162;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          rx_ready_in;
  logic [PL-1:0] rx_data_in;
  logic          rx_rst_out;
  logic [PL-1:0] pkt_out;
  logic          pkt_valid_out;
  logic          pkt_ready_in;
  logic          busy_out;
  logic [7:0]    pkt_count_out, bad_count_out, drop_count_out, timeout_count_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [PL-1:0] d1, d2, d3, dbad;

  uar_pkt_ctrl #(
    .PKT_LNGTH(PL), .TIMEOUT_CYCLES(100), .RST_PULSE(4), .HDR_VAL(8'hA5)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rx_ready_in(rx_ready_in),
    .rx_data_in(rx_data_in), .rx_rst_out(rx_rst_out), .pkt_out(pkt_out),
    .pkt_valid_out(pkt_valid_out), .pkt_ready_in(pkt_ready_in),
    .busy_out(busy_out), .pkt_count_out(pkt_count_out),
    .bad_count_out(bad_count_out), .drop_count_out(drop_count_out),
    .timeout_count_out(timeout_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [PL-1:0] obs, input logic [PL-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Receiver drops ready for n_low cycles, then raises it with the packet;
  // downstream ready is driven only on the capture edge.
  task automatic recv_pkt(input int n_low, input logic [PL-1:0] data, input logic rdy);
    rx_ready_in = 1'b0;
    step(n_low);
    rx_data_in   = data;
    rx_ready_in  = 1'b1;
    pkt_ready_in = rdy;
    step(1);
    pkt_ready_in = 1'b0;
  endtask

  initial begin
    d1   = {2'b11, {19{8'h3D}}, 8'hA5};
    d2   = {2'b01, {19{8'hC2}}, 8'hA5};
    d3   = {2'b10, {19{8'h5E}}, 8'hA5};
    dbad = {2'b00, {19{8'h77}}, 8'h3C};

    rst_in = 1'b1; rx_ready_in = 1'b1; pkt_ready_in = 1'b0; rx_data_in = '0;
    step(2);
    rst_in = 1'b0;
    step(1);
    check("rst_valid", PL'(pkt_valid_out), PL'(0));
    check("rst_pkt", pkt_out, '0);
    check("rst_busy", PL'(busy_out), PL'(0));
    check("rst_rxrst", PL'(rx_rst_out), PL'(0));
    check("rst_cnts", PL'({pkt_count_out, bad_count_out, drop_count_out, timeout_count_out}), PL'(0));

    // First good packet, checking busy mid-receive
    rx_ready_in = 1'b0;
    step(10);
    check("busy_recv", PL'(busy_out), PL'(1));
    step(40);
    rx_data_in = d1; rx_ready_in = 1'b1;
    step(1);
    check("p1_valid", PL'(pkt_valid_out), PL'(1));
    check("p1_data", pkt_out, d1);
    check("p1_cnt", PL'(pkt_count_out), PL'(1));
    check("p1_busy", PL'(busy_out), PL'(0));

    // Second good packet while first unconsumed -> dropped
    recv_pkt(20, d2, 1'b0);
    check("drop_cnt", PL'(drop_count_out), PL'(1));
    check("drop_data", pkt_out, d1);
    check("drop_pcnt", PL'(pkt_count_out), PL'(1));

    // Consumed on the capture cycle -> replaced, valid stays high
    recv_pkt(20, d3, 1'b1);
    check("repl_data", pkt_out, d3);
    check("repl_valid", PL'(pkt_valid_out), PL'(1));
    check("repl_pcnt", PL'(pkt_count_out), PL'(2));
    check("repl_drop", PL'(drop_count_out), PL'(1));

    // Bad header
    recv_pkt(20, dbad, 1'b0);
    check("bad_cnt", PL'(bad_count_out), PL'(1));
    check("bad_valid", PL'(pkt_valid_out), PL'(1));
    check("bad_data", pkt_out, d3);

    // Consume while idle
    pkt_ready_in = 1'b1;
    step(1);
    pkt_ready_in = 1'b0;
    check("cons_valid", PL'(pkt_valid_out), PL'(0));

    // Timeout with ready held low for 200 cycles
    rx_ready_in = 1'b0;
    step(1);
    check("to_busy", PL'(busy_out), PL'(1));
    step(99);
    check("to_pre_rst", PL'(rx_rst_out), PL'(0));
    check("to_pre_cnt", PL'(timeout_count_out), PL'(0));
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("to_pulse", PL'(rx_rst_out), PL'(1));
    end
    check("to_cnt", PL'(timeout_count_out), PL'(1));
    step(1);
    check("to_post_rst", PL'(rx_rst_out), PL'(0));
    check("to_post_busy", PL'(busy_out), PL'(0));
    step(95);
    rx_data_in = d1; rx_ready_in = 1'b1;
    step(2);
    check("to_idle_rise", PL'(pkt_count_out), PL'(2));

    // Second timeout, rise during RXRST is ignored
    rx_ready_in = 1'b0;
    step(101);
    check("to2_pulse", PL'(rx_rst_out), PL'(1));
    rx_data_in = d1; rx_ready_in = 1'b1;
    step(5);
    check("to2_pcnt", PL'(pkt_count_out), PL'(2));
    check("to2_valid", PL'(pkt_valid_out), PL'(0));
    check("to2_cnt", PL'(timeout_count_out), PL'(2));
    check("to2_busy", PL'(busy_out), PL'(0));
    check("to2_rst", PL'(rx_rst_out), PL'(0));

    // Bad counter saturation: 1 + 253 = 254, then 3 more saturate
    for (int i = 0; i < 253; i++) recv_pkt(2, dbad, 1'b0);
    check("bad_254", PL'(bad_count_out), PL'(8'hFE));
    for (int i = 0; i < 3; i++) recv_pkt(2, dbad, 1'b0);
    check("bad_sat", PL'(bad_count_out), PL'(8'hFF));
    check("bad_sat_pcnt", PL'(pkt_count_out), PL'(2));

    // Load a packet, then reset in the middle of a receive
    recv_pkt(5, d1, 1'b0);
    check("pre_rst_valid", PL'(pkt_valid_out), PL'(1));
    check("pre_rst_pcnt", PL'(pkt_count_out), PL'(3));
    rx_ready_in = 1'b0;
    step(30);
    rst_in = 1'b1;
    step(1);
    check("mid_rst_valid", PL'(pkt_valid_out), PL'(0));
    check("mid_rst_pkt", pkt_out, '0);
    check("mid_rst_busy", PL'(busy_out), PL'(0));
    check("mid_rst_cnts", PL'({pkt_count_out, bad_count_out, drop_count_out, timeout_count_out}), PL'(0));
    rst_in = 1'b0; rx_data_in = d2; rx_ready_in = 1'b1;
    step(3);
    check("post_rst_pcnt", PL'(pkt_count_out), PL'(0));
    check("post_rst_valid", PL'(pkt_valid_out), PL'(0));
    check("post_rst_busy", PL'(busy_out), PL'(0));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
